vga_text_gen: RTL and testbench
===============================

Name: vga_text_gen

Overview:
- Drives the text-mode display path for a 640x480 VGA output with an 80x30 character grid.
- Owns the horizontal and vertical timing counters and issues read addresses to the external text-buffer RAM.
- Supplies ascii, pix_x and pix_y to symbol_mem and consumes its bg_fg bit.
- Delays sync and display-enable so they arrive with the foreground/background colour mux output.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- COLS, 80, character columns (H_VIS/8)
- ROWS, 30, character rows (V_VIS/16)

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- pix_en  in  1  pixel strobe; every pipeline stage advances only when pix_en=1
- fg_color  in  12  foreground RGB 4:4:4
- bg_color  in  12  background RGB 4:4:4
- text_addr  out  12  text RAM read address, row*COLS+col
- text_rdata  in  8  text RAM data; synchronous read, 1 clk latency
- ascii  out  8  character code to symbol_mem
- pix_x  out  3  glyph column to symbol_mem
- pix_y  out  4  glyph row to symbol_mem
- bg_fg  in  1  glyph bit from symbol_mem; 1 clk latency
- rgb  out  12  pixel colour
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- de  out  1  display enable, high in the visible area

Behaviour:
- Reset, asynchronous while resetn=0: h_cnt=0, v_cnt=0, ascii=0, pix_x=0, pix_y=0, rgb=0, de=0, hsync=1, vsync=1, all pipeline registers cleared. A mid-frame reset restarts the frame at (0,0) on the first pix_en after release.
- Counters (S0), updated on pix_en:
  - h_cnt counts 0..H_TOT-1, where H_TOT = sum of the H_* parameters = 800.
  - At h_cnt = H_TOT-1, h_cnt goes to 0 and v_cnt increments.
  - v_cnt wraps 0..V_TOT-1, where V_TOT = 525. At (799,524) both counters go to 0 on the same strobe.
- text_addr:
  - Combinational from S0: (v_cnt>>4)*COLS + (h_cnt>>3).
  - Outside the visible area it is forced to 0.
  - Maximum value is 2399.
  - The multiply is implemented as (row<<6)+(row<<4).
- S1, on the next pix_en:
  - ascii <= text_rdata; pix_x <= h_cnt[2:0]; pix_y <= v_cnt[3:0].
  - vis1 <= (h_cnt<H_VIS && v_cnt<V_VIS).
  - hs1 <= ~(H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC); vs1 is the analogous vertical term.
  - text_rdata is stable by then because text_addr changed at least 1 clk earlier.
- S2, on the next pix_en:
  - rgb <= vis1 ? (bg_fg ? fg_color : bg_color) : 0.
  - de <= vis1; hsync <= hs1; vsync <= vs1.
- Latency: a pixel whose counters are present after strobe k produces rgb/hsync/vsync/de after strobe k+2, i.e. 2 pix_en strobes. Sync and rgb are always mutually aligned.
- pix_en low: every register holds its value; outputs are frozen.
- pix_en high every clk is legal. The 1-clk memory latencies are met in that case.
- fg_color and bg_color are sampled in S2 with no extra registering. A colour change takes effect on the next strobe.

Decomposition:
- Package vga_text_pkg holds:
  - default timing constants and derived H_TOT/V_TOT;
  - CHAR_W=8 and CHAR_H=16;
  - widths: H_CNT_W=10, V_CNT_W=10, TEXT_AW=12;
  - typedef rgb444_t (logic [11:0]).
- Sub-module vga_sync_cnt holds h_cnt/v_cnt with wrap logic and outputs counters, visible, hs and vs combinationally. vga_text_gen instantiates it and adds the address generation and the S1/S2 pipeline.

Test Plan:
- Reset: hold resetn=0 with pix_en toggling -> rgb=0, de=0, hsync=1, vsync=1, text_addr=0. Release -> h_cnt reaches 1 after the first strobe.
- Address sequence, pix_en every clk: h=0..7,v=0 -> text_addr=0; h=8 -> 1; v=16,h=0 -> 80; v=479,h=639 -> 2399; h=640 -> 0.
- Sync timing: line 0 -> hsync low for exactly 96 strobes, starting 2 strobes after h_cnt=656. vsync low for 2 lines (v=490,491) with the same 2-strobe skew. de high for 640 strobes per visible line.
- Wrap: run from (799,524) -> next strobe (0,0). Full frame = 420000 strobes between successive vsync falling edges.
- Colour path: model text RAM returns 0x41 and model symbol_mem returns a row pattern 0x18; fg=0xFFF, bg=0x000 -> rgb = 0,0,0,0xFFF,0xFFF,0,0,0 for pixels h=0..7. ascii=0x41, pix_y=row, 2-strobe alignment checked.
- Stall and mid-frame reset: pix_en=1 every 4th clk -> identical output sequence to continuous mode, outputs frozen between strobes. Assert resetn=0 at (300,200) -> immediate reset values; frame restarts at (0,0).

Source files
------------

// File: rtl/vga_text_pkg.sv
// ============================================================================
// Module  : vga_text_pkg
// Brief   : Shared timing defaults, glyph geometry and widths for vga_text_gen
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_text_pkg;

  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  localparam int H_TOT_DEF = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOT_DEF = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;

  localparam int H_CNT_W = 10;
  localparam int V_CNT_W = 10;
  localparam int TEXT_AW = 12;

  typedef logic [11:0] rgb444_t;

endpackage : vga_text_pkg

`default_nettype wire

// File: rtl/vga_sync_cnt.sv
// ============================================================================
// Module  : vga_sync_cnt
// Brief   : Horizontal/vertical raster counters with visible and sync decode
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_cnt
  import vga_text_pkg::*;
#(
  parameter int H_VIS  = H_VIS_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               pix_en,
  output logic [H_CNT_W-1:0] h_cnt,
  output logic [V_CNT_W-1:0] v_cnt,
  output logic               visible,
  output logic               hs,
  output logic               vs
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [H_CNT_W-1:0] C_H_LAST     = H_CNT_W'(H_TOT - 1);
  localparam logic [V_CNT_W-1:0] C_V_LAST     = V_CNT_W'(V_TOT - 1);
  localparam logic [H_CNT_W-1:0] C_H_VIS      = H_CNT_W'(H_VIS);
  localparam logic [V_CNT_W-1:0] C_V_VIS      = V_CNT_W'(V_VIS);
  localparam logic [H_CNT_W-1:0] C_HS_START   = H_CNT_W'(H_VIS + H_FP);
  localparam logic [H_CNT_W-1:0] C_HS_END     = H_CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [V_CNT_W-1:0] C_VS_START   = V_CNT_W'(V_VIS + V_FP);
  localparam logic [V_CNT_W-1:0] C_VS_END     = V_CNT_W'(V_VIS + V_FP + V_SYNC);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == C_H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == C_V_LAST) ? '0 : v_cnt + V_CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + H_CNT_W'(1);
      end
    end
  end

  assign visible = (h_cnt < C_H_VIS) && (v_cnt < C_V_VIS);
  // Sync pulses are active-low: hs/vs drop only inside the sync window.
  assign hs = !((h_cnt >= C_HS_START) && (h_cnt < C_HS_END));
  assign vs = !((v_cnt >= C_VS_START) && (v_cnt < C_VS_END));

endmodule : vga_sync_cnt

`default_nettype wire

// File: rtl/vga_text_gen.sv
// ============================================================================
// Module  : vga_text_gen
// Brief   : 80x30 text-mode VGA pixel pipeline: address gen, glyph fetch, colour
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_text_gen
  import vga_text_pkg::*;
#(
  parameter int H_VIS  = H_VIS_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF,
  parameter int COLS   = H_VIS / CHAR_W,
  parameter int ROWS   = V_VIS / CHAR_H
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pix_en,
  input  logic [11:0] fg_color,
  input  logic [11:0] bg_color,
  output logic [11:0] text_addr,
  input  logic [7:0]  text_rdata,
  output logic [7:0]  ascii,
  output logic [2:0]  pix_x,
  output logic [3:0]  pix_y,
  input  logic        bg_fg,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        de
);

  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic               visible;
  logic               hs0;
  logic               vs0;

  vga_sync_cnt #(
    .H_VIS  (H_VIS),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_VIS  (V_VIS),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) u_sync_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .pix_en  (pix_en),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .visible (visible),
    .hs      (hs0),
    .vs      (vs0)
  );

  localparam logic [TEXT_AW-1:0] C_ROWS = TEXT_AW'(ROWS);

  logic [TEXT_AW-1:0] char_row;
  logic [TEXT_AW-1:0] char_col;
  logic [TEXT_AW-1:0] row_base;

  assign char_row = TEXT_AW'(v_cnt[V_CNT_W-1:4]);
  assign char_col = TEXT_AW'(h_cnt[H_CNT_W-1:3]);

  if (COLS == 80) begin : g_mul80
    assign row_base = (char_row << 6) + (char_row << 4);
  end else begin : g_mul_any
    assign row_base = char_row * TEXT_AW'(COLS);
  end

  // The row guard keeps the address inside the grid even if V_VIS is not a
  // multiple of the glyph height.
  assign text_addr = (visible && (char_row < C_ROWS)) ? row_base + char_col : '0;

  logic vis1;
  logic hs1;
  logic vs1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ascii <= '0;
      pix_x <= '0;
      pix_y <= '0;
      vis1  <= 1'b0;
      hs1   <= 1'b1;
      vs1   <= 1'b1;
    end else if (pix_en) begin
      ascii <= text_rdata;
      pix_x <= h_cnt[2:0];
      pix_y <= v_cnt[3:0];
      vis1  <= visible;
      hs1   <= hs0;
      vs1   <= vs0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rgb   <= '0;
      de    <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pix_en) begin
      rgb   <= vis1 ? (bg_fg ? fg_color : bg_color) : '0;
      de    <= vis1;
      hsync <= hs1;
      vsync <= vs1;
    end
  end

endmodule : vga_text_gen

`default_nettype wire

// File: tb/tb_vga_text_gen.sv
// ============================================================================
// Module  : tb_vga_text_gen
// Brief   : Self-checking bench for vga_text_gen with a strobe-index model
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_text_gen;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VIS  = 32;
  localparam int V_FP   = 2;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 3;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME  = H_TOT * V_TOT;
  localparam int NCOLS  = H_VIS / 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        pix_en = 1'b0;
  logic [11:0] fg_color = 12'hFFF;
  logic [11:0] bg_color = 12'h000;
  logic [11:0] text_addr;
  logic [7:0]  text_rdata;
  logic [7:0]  ascii;
  logic [2:0]  pix_x;
  logic [3:0]  pix_y;
  logic        bg_fg;
  logic [11:0] rgb;
  logic        hsync;
  logic        vsync;
  logic        de;

  logic [7:0] text_mem [0:4095];
  logic [7:0] glyph    [0:4095];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vga_text_gen #(
    .H_VIS (H_VIS), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_VIS (V_VIS), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pix_en     (pix_en),
    .fg_color   (fg_color),
    .bg_color   (bg_color),
    .text_addr  (text_addr),
    .text_rdata (text_rdata),
    .ascii      (ascii),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .bg_fg      (bg_fg),
    .rgb        (rgb),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de)
  );

  // Memory models: registered reads that settle within one clock of the address.
  always @(negedge clk) text_rdata <= text_mem[text_addr];
  always @(negedge clk) bg_fg <= glyph[{ascii, pix_y}][3'd7 - pix_x];

  // Reference: everything follows from the number of strobes since reset.
  int          n;
  logic [11:0] s_fg;
  logic [11:0] s_bg;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      n    <= 0;
      s_fg <= '0;
      s_bg <= '0;
    end else if (pix_en) begin
      n    <= n + 1;
      s_fg <= fg_color;
      s_bg <= bg_color;
    end
  end

  function automatic int addr_of(input int idx);
    int h;
    int v;
    h = idx % H_TOT;
    v = idx / H_TOT;
    if (h < H_VIS && v < V_VIS) return (v / 16) * NCOLS + h / 8;
    return 0;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (strobe %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic check_all();
    int          idx;
    int          h;
    int          v;
    int          ch;
    logic        vis;
    logic        pbit;
    logic [11:0] e_rgb;
    check_val("text_addr", text_addr, addr_of(n % FRAME));
    if (n >= 1) begin
      idx = (n - 1) % FRAME;
      h   = idx % H_TOT;
      v   = idx / H_TOT;
      check_val("ascii", ascii, text_mem[addr_of(idx)]);
      check_val("pix_x", pix_x, h % 8);
      check_val("pix_y", pix_y, v % 16);
    end else begin
      check_val("ascii", ascii, 0);
      check_val("pix_x", pix_x, 0);
      check_val("pix_y", pix_y, 0);
    end
    if (n >= 2) begin
      idx   = (n - 2) % FRAME;
      h     = idx % H_TOT;
      v     = idx / H_TOT;
      vis   = (h < H_VIS) && (v < V_VIS);
      ch    = text_mem[addr_of(idx)];
      pbit  = glyph[ch * 16 + v % 16][7 - h % 8];
      e_rgb = vis ? (pbit ? s_fg : s_bg) : 12'h000;
      check_val("rgb", rgb, e_rgb);
      check_val("de", de, vis);
      check_val("hsync", hsync, !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC));
      check_val("vsync", vsync, !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC));
    end else begin
      check_val("rgb", rgb, 0);
      check_val("de", de, 0);
      check_val("hsync", hsync, 1);
      check_val("vsync", vsync, 1);
    end
  endtask

  logic chk_en = 1'b0;
  logic prev_vs = 1'b1;
  int   last_fall = -1;
  int   frames_seen = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check_all();
      if (prev_vs && !vsync) begin
        if (last_fall >= 0) begin
          check_val("frame_len", n - last_fall, FRAME);
          frames_seen++;
        end
        last_fall = n;
      end
      prev_vs = vsync;
    end
  end

  initial begin
    int found;
    for (int i = 0; i < 4096; i++) begin
      text_mem[i] = 8'($urandom);
      glyph[i]    = 8'($urandom);
    end
    text_mem[0] = 8'h41;
    for (int r = 0; r < 16; r++) glyph[8'h41 * 16 + r] = 8'h18;

    #1 resetn = 1'b0;
    #1 chk_en = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #3 pix_en = ~pix_en;
    end
    @(posedge clk);
    #3 resetn = 1'b1;
    pix_en = 1'b1;

    // Continuous strobes across two vsync falls, occasional colour changes.
    repeat (59000) begin
      @(posedge clk);
      #3;
      if ($urandom_range(0, 255) == 0) fg_color = 12'($urandom);
      if ($urandom_range(0, 255) == 0) bg_color = 12'($urandom);
    end

    repeat (3000) begin
      @(posedge clk);
      #3 pix_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) fg_color = 12'($urandom);
    end

    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #3 pix_en = (i % 4 == 3);
    end

    // Mid-line asynchronous reset at h=300.
    @(posedge clk);
    #3 pix_en = 1'b1;
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      @(posedge clk);
      #2;
      if ((n % FRAME) % H_TOT == 300) found = 1;
    end
    check_val("wait_h300", found, 1);
    resetn    = 1'b0;
    last_fall = -1;
    prev_vs   = 1'b1;
    #1 check_all();
    repeat (4) begin
      @(posedge clk);
      #3 pix_en = ~pix_en;
    end
    @(posedge clk);
    #3 resetn = 1'b1;
    pix_en = 1'b1;
    repeat (2000) @(posedge clk);

    @(negedge clk);
    chk_en = 1'b0;
    check_val("frames_seen", frames_seen > 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_vga_text_gen

`default_nettype wire
